// File: rtl/pacman_pkg.sv
// Shared game constants, coordinate types and the collision FSM state enum
// (the enum is also consumed by the debug overlay).
package pacman_pkg;

    localparam int SCR_W       = 1920;
    localparam int SCR_H       = 1080;
    localparam int COORD_W     = 12;
    localparam int ENEMY_SIZE  = 40;
    localparam int PLAYER_SIZE = 40;
    localparam int N_ENEMY     = 4;
    localparam int IDX_W       = $clog2(N_ENEMY);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HIT,
        OVER
    } state_t;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/collision_ctrl_box_overlap.sv
// Combinational axis-aligned bounding-box overlap test between two squares.
// Far edges are formed one bit wider so coordinates near 4095 cannot wrap.
module box_overlap
    import pacman_pkg::*;
(
    input  logic [COORD_W-1:0] a_x,
    input  logic [COORD_W-1:0] a_y,
    input  logic [COORD_W-1:0] a_size,
    input  logic [COORD_W-1:0] b_x,
    input  logic [COORD_W-1:0] b_y,
    input  logic [COORD_W-1:0] b_size,
    output logic               hit
);

    logic [COORD_W:0] a_x_w;
    logic [COORD_W:0] a_y_w;
    logic [COORD_W:0] b_x_w;
    logic [COORD_W:0] b_y_w;
    logic [COORD_W:0] a_x_end;
    logic [COORD_W:0] a_y_end;
    logic [COORD_W:0] b_x_end;
    logic [COORD_W:0] b_y_end;

    assign a_x_w   = {1'b0, a_x};
    assign a_y_w   = {1'b0, a_y};
    assign b_x_w   = {1'b0, b_x};
    assign b_y_w   = {1'b0, b_y};
    assign a_x_end = a_x_w + {1'b0, a_size};
    assign a_y_end = a_y_w + {1'b0, a_size};
    assign b_x_end = b_x_w + {1'b0, b_size};
    assign b_y_end = b_y_w + {1'b0, b_size};

    // Strict compares: boxes that only share an edge are not a collision.
    assign hit = (a_x_w < b_x_end) && (b_x_w < a_x_end) &&
                 (a_y_w < b_y_end) && (b_y_w < a_y_end);

endmodule

// File: rtl/collision_ctrl.sv
// Player/enemy collision controller: snapshots positions per frame, scans the
// enemies one per cycle, tracks lives/cooldown/game-over and pulses game_reset.
// Optional hit counter output enabled by defining COLLISION_HIT_COUNT_EN.
module collision_ctrl
    import pacman_pkg::*;
#(
    parameter int PLAYER_SIZE     = 40,
    parameter int ENEMY_SIZE      = 40,
    parameter int LIVES           = 3,
    parameter int COOLDOWN_FRAMES = 60
) (
    input  logic               clk_pix,
    input  logic               rstn,
    input  logic               frame_tick,
    input  logic               restart,
    input  logic [COORD_W-1:0] player_x,
    input  logic [COORD_W-1:0] player_y,
    input  logic [COORD_W-1:0] enemy0_x,
    input  logic [COORD_W-1:0] enemy0_y,
    input  logic [COORD_W-1:0] enemy1_x,
    input  logic [COORD_W-1:0] enemy1_y,
    input  logic [COORD_W-1:0] enemy2_x,
    input  logic [COORD_W-1:0] enemy2_y,
    input  logic [COORD_W-1:0] enemy3_x,
    input  logic [COORD_W-1:0] enemy3_y,
    output logic               game_reset,
    output logic [1:0]         hit_idx,
    output logic [1:0]         lives,
    output logic               game_over,
    output logic               busy
`ifdef COLLISION_HIT_COUNT_EN
    ,
    output logic [15:0]        hit_count
`endif
);

    localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
    localparam logic [7:0]       COOL_INIT  = 8'(COOLDOWN_FRAMES);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_ENEMY - 1);

    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] hit_idx_reg;
    logic [1:0]       lives_reg;
    logic [7:0]       cooldown_reg;
    logic             game_reset_reg;
    logic             game_over_reg;
    logic             busy_reg;

    logic [COORD_W-1:0] enemy_x_in [N_ENEMY];
    logic [COORD_W-1:0] enemy_y_in [N_ENEMY];
    logic [COORD_W-1:0] snap_ex    [N_ENEMY];
    logic [COORD_W-1:0] snap_ey    [N_ENEMY];
    logic [COORD_W-1:0] snap_px_reg;
    logic [COORD_W-1:0] snap_py_reg;
    logic               snap_en;
    logic               scan_hit;

    assign enemy_x_in[0] = enemy0_x;
    assign enemy_y_in[0] = enemy0_y;
    assign enemy_x_in[1] = enemy1_x;
    assign enemy_y_in[1] = enemy1_y;
    assign enemy_x_in[2] = enemy2_x;
    assign enemy_y_in[2] = enemy2_y;
    assign enemy_x_in[3] = enemy3_x;
    assign enemy_y_in[3] = enemy3_y;

    // Same condition that moves the FSM from IDLE into SCAN.
    assign snap_en = (state_reg == IDLE) && frame_tick && (cooldown_reg == 8'd0);

    always_ff @(posedge clk_pix or negedge rstn) begin
        if (!rstn) begin
            snap_px_reg <= '0;
            snap_py_reg <= '0;
        end else if (snap_en) begin
            snap_px_reg <= player_x;
            snap_py_reg <= player_y;
        end
    end

    generate
        for (genvar gi = 0; gi < N_ENEMY; gi++) begin : g_snap
            logic [COORD_W-1:0] ex_reg;
            logic [COORD_W-1:0] ey_reg;

            always_ff @(posedge clk_pix or negedge rstn) begin
                if (!rstn) begin
                    ex_reg <= '0;
                    ey_reg <= '0;
                end else if (snap_en) begin
                    ex_reg <= enemy_x_in[gi];
                    ey_reg <= enemy_y_in[gi];
                end
            end

            assign snap_ex[gi] = ex_reg;
            assign snap_ey[gi] = ey_reg;
        end
    endgenerate

    box_overlap u_box_overlap (
        .a_x    (snap_px_reg),
        .a_y    (snap_py_reg),
        .a_size (COORD_W'(PLAYER_SIZE)),
        .b_x    (snap_ex[idx_reg]),
        .b_y    (snap_ey[idx_reg]),
        .b_size (COORD_W'(ENEMY_SIZE)),
        .hit    (scan_hit)
    );

    always_ff @(posedge clk_pix or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            hit_idx_reg    <= '0;
            lives_reg      <= LIVES_INIT;
            cooldown_reg   <= 8'd0;
            game_reset_reg <= 1'b0;
            game_over_reg  <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            game_reset_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (frame_tick) begin
                        if (cooldown_reg != 8'd0) begin
                            cooldown_reg <= cooldown_reg - 8'd1;
                        end else begin
                            state_reg <= SCAN;
                            idx_reg   <= '0;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    // Scan stops at the first overlap, so the lowest index wins.
                    if (scan_hit) begin
                        hit_idx_reg    <= idx_reg;
                        game_reset_reg <= 1'b1;
                        state_reg      <= HIT;
                    end else if (idx_reg == LAST_IDX) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                HIT: begin
                    lives_reg    <= lives_reg - 2'd1;
                    cooldown_reg <= COOL_INIT;
                    busy_reg     <= 1'b0;
                    if (lives_reg == 2'd1) begin
                        state_reg     <= OVER;
                        game_over_reg <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                OVER: begin
                    if (restart) begin
                        lives_reg      <= LIVES_INIT;
                        cooldown_reg   <= COOL_INIT;
                        game_reset_reg <= 1'b1;
                        game_over_reg  <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign game_reset = game_reset_reg;
    assign hit_idx    = hit_idx_reg;
    assign lives      = lives_reg;
    assign game_over  = game_over_reg;
    assign busy       = busy_reg;

`ifdef COLLISION_HIT_COUNT_EN
    logic [15:0] hit_count_reg;

    // Lifetime statistic: survives restart, saturates instead of wrapping.
    always_ff @(posedge clk_pix or negedge rstn) begin
        if (!rstn) begin
            hit_count_reg <= 16'd0;
        end else if ((state_reg == HIT) && (hit_count_reg != 16'hFFFF)) begin
            hit_count_reg <= hit_count_reg + 16'd1;
        end
    end

    assign hit_count = hit_count_reg;
`endif

endmodule

// File: tb/tb_collision_ctrl.sv
// Directed bench for collision_ctrl: a frame-level scoreboard predicts every
// output each cycle, plus literal checks on the key scenarios.
`timescale 1ns/1ps
module tb_collision_ctrl;

    localparam int COOL   = 60;
    localparam int LIVES0 = 3;
    localparam int SZ     = 40;

    logic        clk_pix    = 1'b0;
    logic        rstn       = 1'b0;
    logic        frame_tick = 1'b0;
    logic        restart    = 1'b0;
    logic [11:0] player_x   = 12'd0;
    logic [11:0] player_y   = 12'd0;
    logic [11:0] e_x [4];
    logic [11:0] e_y [4];
    logic        game_reset;
    logic [1:0]  hit_idx;
    logic [1:0]  lives;
    logic        game_over;
    logic        busy;
`ifdef COLLISION_HIT_COUNT_EN
    logic [15:0] hit_count;
`endif

    int cyc       = 0;
    int n_checks  = 0;
    int n_fail    = 0;
    int n_pulses  = 0;
    int last_pulse = -1;

    collision_ctrl #(
        .PLAYER_SIZE     (SZ),
        .ENEMY_SIZE      (SZ),
        .LIVES           (LIVES0),
        .COOLDOWN_FRAMES (COOL)
    ) dut (
        .clk_pix    (clk_pix),
        .rstn       (rstn),
        .frame_tick (frame_tick),
        .restart    (restart),
        .player_x   (player_x),
        .player_y   (player_y),
        .enemy0_x   (e_x[0]),
        .enemy0_y   (e_y[0]),
        .enemy1_x   (e_x[1]),
        .enemy1_y   (e_y[1]),
        .enemy2_x   (e_x[2]),
        .enemy2_y   (e_y[2]),
        .enemy3_x   (e_x[3]),
        .enemy3_y   (e_y[3]),
        .game_reset (game_reset),
        .hit_idx    (hit_idx),
        .lives      (lives),
        .game_over  (game_over),
        .busy       (busy)
`ifdef COLLISION_HIT_COUNT_EN
        ,
        .hit_count  (hit_count)
`endif
    );

    always #5 clk_pix = ~clk_pix;
    always @(posedge clk_pix) cyc <= cyc + 1;

    function automatic void check(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endfunction

    function automatic bit overlaps(int px, int py, int ex, int ey);
        return (px < ex + SZ) && (ex < px + SZ) && (py < ey + SZ) && (ey < py + SZ);
    endfunction

    // Frame-level scoreboard: when a tick is accepted the outcome of the whole
    // scan is computed at once and its visible effects are scheduled by cycle.
    int m_lives, m_cool, m_over, m_hit_idx, m_hits;
    int ev, ev_idx, rs, bf, bt, k;
    bit exp_gr;

    initial begin
        m_lives = LIVES0; m_cool = 0; m_over = 0; m_hit_idx = 0; m_hits = 0;
        ev = -1; ev_idx = 0; rs = -1; bf = 0; bt = -1;
        forever begin
            @(negedge clk_pix);
            exp_gr = 1'b0;
            if (!rstn) begin
                m_lives = LIVES0; m_cool = 0; m_over = 0; m_hit_idx = 0; m_hits = 0;
                ev = -1; rs = -1; bf = 0; bt = -1;
            end else begin
                if (ev >= 0 && cyc == ev + 1) begin
                    m_lives--;
                    m_cool = COOL;
                    if (m_hits < 65535) m_hits++;
                    if (m_lives == 0) m_over = 1;
                    ev = -1;
                end
                if (ev >= 0 && cyc == ev) begin
                    exp_gr = 1'b1;
                    m_hit_idx = ev_idx;
                end
                if (rs >= 0 && cyc == rs) begin
                    exp_gr = 1'b1;
                    m_lives = LIVES0; m_cool = COOL; m_over = 0;
                    rs = -1;
                end
            end
            if (game_reset) begin
                n_pulses++;
                last_pulse = cyc;
            end
            check("game_reset", int'(game_reset), int'(exp_gr));
            check("hit_idx", int'(hit_idx), m_hit_idx);
            check("lives", int'(lives), m_lives);
            check("game_over", int'(game_over), m_over);
            check("busy", int'(busy), (cyc >= bf && cyc <= bt) ? 1 : 0);
`ifdef COLLISION_HIT_COUNT_EN
            check("hit_count", int'(hit_count), m_hits);
`endif
            if (rstn) begin
                if (m_over != 0) begin
                    if (restart && rs < 0) rs = cyc + 1;
                end else if (frame_tick && !(cyc >= bf && cyc <= bt)) begin
                    if (m_cool > 0) begin
                        m_cool--;
                    end else begin
                        k = -1;
                        for (int i = 0; i < 4; i++)
                            if (k < 0 && overlaps(player_x, player_y, e_x[i], e_y[i])) k = i;
                        bf = cyc + 1;
                        if (k >= 0) begin
                            bt = cyc + 2 + k;
                            ev = cyc + 2 + k;
                            ev_idx = k;
                        end else begin
                            bt = cyc + 4;
                        end
                    end
                end
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk_pix);
            #1;
        end
    endtask

    task automatic do_tick(output int t);
        t = cyc;
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    task automatic burn(int n);
        int t;
        for (int i = 0; i < n; i++) begin
            do_tick(t);
            step(2);
        end
    endtask

    task automatic place(int px, int py, int x0, int y0, int x1, int y1,
                         int x2, int y2, int x3, int y3);
        player_x = 12'(px); player_y = 12'(py);
        e_x[0] = 12'(x0); e_y[0] = 12'(y0);
        e_x[1] = 12'(x1); e_y[1] = 12'(y1);
        e_x[2] = 12'(x2); e_y[2] = 12'(y2);
        e_x[3] = 12'(x3); e_y[3] = 12'(y3);
    endtask

    initial begin
        int t, p0;
        place(100, 100, 0, 0, 1800, 0, 0, 1000, 1800, 1000);
        step(3);
        check("rst_lives", int'(lives), 3);
        check("rst_busy", int'(busy), 0);
        check("rst_game_over", int'(game_over), 0);
        check("rst_game_reset", int'(game_reset), 0);
        rstn = 1'b1;
        step(2);

        // No-hit scan; player moved onto enemy0 mid-scan must not matter
        p0 = n_pulses;
        do_tick(t);
        player_x = 12'd0; player_y = 12'd0;
        check("t1_busy_first", int'(busy), 1);
        step(3);
        check("t1_busy_last", int'(busy), 1);
        step(1);
        check("t1_idle", int'(busy), 0);
        step(2);
        check("t1_no_pulse", n_pulses - p0, 0);
        check("t1_lives", int'(lives), 3);

        // Hit on enemy0, then 60 ignored ticks despite overlap
        p0 = n_pulses;
        do_tick(t);
        step(5);
        check("t2_pulse_cyc", last_pulse, t + 2);
        check("t2_pulses", n_pulses - p0, 1);
        check("t2_lives", int'(lives), 2);
        check("t2_hit_idx", int'(hit_idx), 0);
        p0 = n_pulses;
        burn(COOL);
        check("t2_cooldown", n_pulses - p0, 0);
        place(500, 500, 0, 0, 1800, 0, 0, 1000, 1800, 1000);
        do_tick(t);
        check("t2_scan_after_cool", int'(busy), 1);
        step(6);

        // Priority: enemy1 and enemy3 both overlap
        place(1000, 500, 1800, 0, 1039, 539, 0, 1000, 1000, 500);
        p0 = n_pulses;
        do_tick(t);
        step(5);
        check("t3_pulse_cyc", last_pulse, t + 3);
        check("t3_hit_idx", int'(hit_idx), 1);
        check("t3_lives", int'(lives), 1);
        burn(COOL);
        check("t3_pulses", n_pulses - p0, 1);

        // Edge-touching boxes in x and y
        place(1000, 500, 1040, 500, 1800, 0, 1000, 540, 0, 1000);
        p0 = n_pulses;
        do_tick(t);
        check("t3_edge_scan", int'(busy), 1);
        step(6);
        check("t3_edge_no_hit", n_pulses - p0, 0);

        // Final life lost on enemy2
        e_x[2] = 12'd1010; e_y[2] = 12'd510;
        do_tick(t);
        step(6);
        check("t4_pulse_cyc", last_pulse, t + 4);
        check("t4_game_over", int'(game_over), 1);
        check("t4_lives", int'(lives), 0);
        check("t4_hit_idx", int'(hit_idx), 2);
        p0 = n_pulses;
        do_tick(t);
        step(4);
        check("t4_tick_ignored", n_pulses - p0, 0);
        check("t4_still_over", int'(game_over), 1);
        restart = 1'b1;
        step(1);
        check("t4_restart_pulse", int'(game_reset), 1);
        check("t4_restart_lives", int'(lives), 3);
        check("t4_restart_over", int'(game_over), 0);
        step(1);
        check("t4_pulse_single", int'(game_reset), 0);
        restart = 1'b0;
        step(2);

        // 13-bit compare at the top of the coordinate range
        burn(COOL);
        place(4080, 4080, 1040, 500, 1800, 0, 1010, 510, 4095, 4095);
        do_tick(t);
        step(6);
        check("t5_pulse_cyc", last_pulse, t + 5);
        check("t5_hit_idx", int'(hit_idx), 3);
        check("t5_lives", int'(lives), 2);

        // Reset asserted in the middle of a hitting scan
        burn(COOL);
        place(0, 0, 1800, 0, 1800, 1000, 20, 20, 0, 1000);
        p0 = n_pulses;
        do_tick(t);
        step(1);
        rstn = 1'b0;
        step(1);
        check("t6_rst_lives", int'(lives), 3);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_hit_idx", int'(hit_idx), 0);
`ifdef COLLISION_HIT_COUNT_EN
        check("t6_rst_hit_count", int'(hit_count), 0);
`endif
        step(1);
        rstn = 1'b1;
        step(4);
        check("t6_no_pulse", n_pulses - p0, 0);

        // Extra frame_tick during a scan is dropped
        e_x[1] = 12'd30; e_y[1] = 12'd30;
        p0 = n_pulses;
        do_tick(t);
        step(1);
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(5);
        check("t7_pulses", n_pulses - p0, 1);
        check("t7_pulse_cyc", last_pulse, t + 3);
        check("t7_lives", int'(lives), 2);
`ifdef COLLISION_HIT_COUNT_EN
        check("t7_hit_count", int'(hit_count), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
